demux4_reg: RTL and testbench
=============================

// Module: demux4_reg
// PURPOSE
//   Registered 1-to-4 demultiplexer with valid/ready handshake: the inverse of the
//   datapath 4:1 mux. Routes one producer stream to one of four consumer ports by
//   in_sel, holding each word in a one-entry per-port slot until that consumer accepts.
//   Sits between a shared result source and independent sinks (e.g. write-back lanes).
// PARAMETERS
//   WIDTH  32  data width of input and every output port
// PORTS
//   clk        in   1      clock; all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      producer presents in_data/in_sel
//   in_ready   out  1      block can accept this cycle (combinational)
//   in_data    in   WIDTH  word to route
//   in_sel     in   2      destination port 0..3
//   out_valid  out  4      bit k: slot k holds a word for consumer k
//   out_ready  in   4      bit k: consumer k accepts this cycle
//   out_data0  out  WIDTH  slot 0 contents (likewise out_data1..out_data3)
//   occupancy  out  3      number of full slots, 0..4
// BEHAVIOUR
//   - One clock domain; reset synchronous, active-high, sampled on rising clk.
//   - Reset: out_valid=4'b0000, out_data0..3=0, occupancy=0. While rst=1, in_ready=0.
//   - Reset mid-operation discards all held words; no transfer is completed that cycle.
//   - Per slot k: drain_k = out_valid[k] & out_ready[k].
//   - in_ready = !rst & (!out_valid[in_sel] | out_ready[in_sel]); valid even when
//     in_valid=0. in_ready depends on in_sel/out_ready; consumers keep out_ready free of
//     any combinational path from in_ready.
//   - accept = in_valid & in_ready; load_k = accept & (in_sel==k).
//   - Slot k next state:
//       load_k            -> out_data_k<=in_data, out_valid[k]<=1 (also when drain_k)
//       drain_k & !load_k -> out_valid[k]<=0, out_data_k keeps last value
//       otherwise         -> hold
//   - Latency: word accepted at edge N is visible on out_data_k/out_valid[k] after edge N.
//     Back-to-back to one port: one word/cycle when consumer holds out_ready=1.
//   - Stability: while out_valid[k]=1 & out_ready[k]=0, out_data_k and out_valid[k]
//     do not change.
//   - Ports are independent: a stalled port never blocks input selecting another port.
//   - Order preserved per port; no ordering guarantee across ports.
//   - Full: all four slots valid with no drains -> in_ready=0 for every in_sel.
//   - in_data/in_sel ignored when accept=0; in_valid=0 never alters any slot.
//   - occupancy <= occupancy + load - (number of drains), registered. Load and drain
//     on the same slot in one cycle leave it unchanged. Sum of drains is 0..4; 3-bit
//     arithmetic never wraps because occupancy equals popcount(out_valid) at all times.
// TESTING
//   1 Reset: rst=1 two cycles with in_valid=1 -> in_ready=0, out_valid=0, occupancy=0.
//   2 Single route: in_sel=2, in_data=32'hDEADBEEF, out_ready=0 -> after one edge
//     out_valid=4'b0100, out_data2=DEADBEEF, occupancy=1; held 5 cycles unchanged.
//   3 Stall isolation: slot 2 full, out_ready=0; in_sel=2 -> in_ready=0;
//     in_sel=0, data 32'h1 -> accepted, out_valid=4'b0101, occupancy=2.
//   4 Pass-through: out_ready[1]=1, 8 words 1..8 to port 1 on consecutive cycles
//     -> in_ready stays 1, out_data1 yields 1..8 in order, occupancy stays 1.
//   5 Full: fill all 4 slots, out_ready=0 -> occupancy=4, in_ready=0 all in_sel;
//     then out_ready=4'b1111 with load to port 3 -> out_valid=4'b1000, occupancy=1.
//   6 Mid-op reset: 3 slots full, assert rst one cycle -> next cycle out_valid=0,
//     out_data0..3=0, occupancy=0; normal acceptance resumes after rst drops.

Source files
------------

// File: rtl/demux4_reg.sv
// Registered 1-to-4 demultiplexer with per-port one-entry slots.
// Each slot holds its word until that consumer accepts it.
module demux4_reg #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_sel,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [2:0]       occupancy
);

    logic [WIDTH-1:0] slot [4];
    logic [3:0]       drain;
    logic [3:0]       load;
    logic             accept;
    logic [2:0]       ndrain;
    logic [2:0]       occ_nxt;

    assign out_data0 = slot[0];
    assign out_data1 = slot[1];
    assign out_data2 = slot[2];
    assign out_data3 = slot[3];

    // Handshake decode: a port is free when empty or draining this cycle.
    always_comb begin
        drain    = out_valid & out_ready;
        in_ready = !rst && (!out_valid[in_sel] || out_ready[in_sel]);
        accept   = in_valid && in_ready;
        load     = 4'b0000;
        if (accept) begin
            load = 4'b0001 << in_sel;
        end
        ndrain  = {2'b00, drain[0]} + {2'b00, drain[1]}
                + {2'b00, drain[2]} + {2'b00, drain[3]};
        occ_nxt = occupancy + {2'b00, accept} - ndrain;
    end

    // Slot valid bits and occupancy; a load wins over a same-cycle drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 4'b0000;
            occupancy <= 3'd0;
        end else begin
            out_valid <= (out_valid & ~drain) | load;
            occupancy <= occ_nxt;
        end
    end

    // Slot data: captured on load, otherwise keeps its last value.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                slot[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (load[k]) begin
                    slot[k] <= in_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_demux4_reg.sv
// Randomized and directed bench for demux4_reg.
// Reference keeps one queue per consumer port, capacity one.
module tb_demux4_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data0;
    logic [31:0] out_data1;
    logic [31:0] out_data2;
    logic [31:0] out_data3;
    logic [2:0]  occupancy;

    demux4_reg #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int          nvec = 0;
    int          nerr = 0;
    bit          armed = 1'b0;
    logic [31:0] q [4][$];
    logic [31:0] last [4];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp,
                     $time);
        end
    endtask

    function automatic logic [3:0] m_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (q[k].size() != 0);
        return v;
    endfunction

    function automatic logic [31:0] m_occ();
        int n = 0;
        for (int k = 0; k < 4; k++) n += q[k].size();
        return n;
    endfunction

    task automatic check_state();
        check("out_valid", {28'd0, out_valid}, {28'd0, m_valid()});
        check("occupancy", {29'd0, occupancy}, m_occ());
        check("out_data0", out_data0, last[0]);
        check("out_data1", out_data1, last[1]);
        check("out_data2", out_data2, last[2]);
        check("out_data3", out_data3, last[3]);
    endtask

    // One clock: drive, check against model, clock, advance model.
    task automatic cycle(input bit r, input bit iv, input logic [1:0] s,
                         input logic [31:0] d, input logic [3:0] ordy);
        bit exp_rdy;
        rst = r;
        in_valid = iv;
        in_sel = s;
        in_data = d;
        out_ready = ordy;
        #1;
        exp_rdy = !r && !(q[s].size() != 0 && !ordy[s]);
        check("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        if (armed) check_state();
        @(posedge clk);
        if (r) begin
            for (int k = 0; k < 4; k++) begin
                q[k].delete();
                last[k] = '0;
            end
            armed = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (q[k].size() != 0 && ordy[k]) void'(q[k].pop_front());
            end
            if (iv && exp_rdy) begin
                q[s].push_back(d);
                last[s] = d;
            end
        end
        #1;
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_sel = 2'd0;
        in_data = '0;
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) last[k] = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with in_valid high
        cycle(1, 1, 2'd1, 32'h55, 4'b0000);
        cycle(1, 1, 2'd1, 32'h55, 4'b0000);
        cycle(0, 0, 2'd0, 32'h0, 4'b0000);

        // Single route to port 2, then hold five cycles
        cycle(0, 1, 2'd2, 32'hDEADBEEF, 4'b0000);
        check("route_valid", {28'd0, out_valid}, 32'h4);
        check("route_data", out_data2, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) cycle(0, 0, 2'd0, 32'h0, 4'b0000);
        check("route_hold", out_data2, 32'hDEADBEEF);

        // Stall isolation
        in_sel = 2'd2;
        out_ready = 4'b0000;
        #1;
        check("stall_ready", {31'd0, in_ready}, 32'd0);
        cycle(0, 1, 2'd2, 32'hBAD, 4'b0000);
        cycle(0, 1, 2'd0, 32'h1, 4'b0000);
        check("iso_valid", {28'd0, out_valid}, 32'h5);
        check("iso_occ", {29'd0, occupancy}, 32'd2);

        // Drain, then pass-through eight words on port 1
        cycle(0, 0, 2'd0, 32'h0, 4'b1111);
        for (int i = 1; i <= 8; i++) begin
            cycle(0, 1, 2'd1, i, 4'b0010);
            check("pt_data", out_data1, i);
            check("pt_occ", {29'd0, occupancy}, 32'd1);
        end
        cycle(0, 0, 2'd0, 32'h0, 4'b1111);

        // Full condition
        for (int k = 0; k < 4; k++) cycle(0, 1, k[1:0], 32'hA0 + k, 4'b0000);
        check("full_occ", {29'd0, occupancy}, 32'd4);
        for (int k = 0; k < 4; k++) begin
            in_sel = k[1:0];
            in_valid = 1'b1;
            #1;
            check("full_ready", {31'd0, in_ready}, 32'd0);
        end
        cycle(0, 1, 2'd3, 32'hC3, 4'b1111);
        check("full_drain_v", {28'd0, out_valid}, 32'h8);
        check("full_drain_o", {29'd0, occupancy}, 32'd1);

        // Mid-operation reset
        cycle(0, 1, 2'd0, 32'h10, 4'b0000);
        cycle(0, 1, 2'd1, 32'h11, 4'b0000);
        cycle(1, 1, 2'd2, 32'h12, 4'b0000);
        check("mrst_valid", {28'd0, out_valid}, 32'h0);
        check("mrst_occ", {29'd0, occupancy}, 32'd0);
        check("mrst_data3", out_data3, 32'h0);
        cycle(0, 1, 2'd2, 32'h77, 4'b0000);
        check("resume", out_data2, 32'h77);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(0, 63) == 0), $urandom_range(0, 3) != 0,
                  2'($urandom_range(0, 3)), $urandom,
                  4'($urandom_range(0, 15)));
        end
        cycle(0, 0, 2'd0, 32'h0, 4'b0000);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
